// File: rtl/mouse_position_tracker.sv
// ---------------------------------------------------------------------------
// mouse_position_tracker
//
// Reassembles standard 3-byte PS/2 movement packets from the serial
// receiver's byte stream. Each packet's signed X/Y deltas are added to an
// absolute cursor position, which is clamped to a 1024x768 screen.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   rx_data[7:0] in   byte from the PS/2 receiver
//   rx_valid     in   one-cycle strobe qualifying rx_data
//   xpos[11:0]   out  cursor X, 0..XMAX
//   ypos[11:0]   out  cursor Y, 0..YMAX (0 = top of screen)
//   ButtonLeft   out  left button (level, or click pulse, see below)
//   ButtonRight  out  right button level
//   pkt_valid    out  one-cycle pulse when a packet has been applied
//
// Handshake: rx_valid is a single-cycle strobe with no back-pressure. Every
// strobed byte is consumed in the cycle it is presented, and that includes
// the APPLY cycle. pkt_valid marks the single cycle in which newly updated
// outputs first appear. All outputs hold their values between packets.
//
// Optional build macro MOUSE_CLICK_PULSE_EN: when it is defined, ButtonLeft
// becomes a one-cycle pulse on a 0->1 transition of the left bit between
// consecutive packets. The pulse is coincident with pkt_valid.
// ---------------------------------------------------------------------------
module mouse_position_tracker #(
    parameter int XMAX           = 1023,
    parameter int YMAX           = 767,
    parameter int XINIT          = 512,
    parameter int YINIT          = 384,
    parameter int TIMEOUT_CYCLES = 1300000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        ButtonLeft,
    output logic        ButtonRight,
    output logic        pkt_valid
);

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        APPLY   = 2'd3
    } state_t;

    localparam logic [20:0]        TIMEOUT_LIM = 21'(TIMEOUT_CYCLES);
    localparam logic signed [13:0] XMAX_S      = 14'(XMAX);
    localparam logic signed [13:0] YMAX_S      = 14'(YMAX);

    state_t      state;
    state_t      state_next;
    logic [7:0]  hdr;
    logic [7:0]  dx_byte;
    logic [7:0]  dy_byte;
    logic [20:0] timeout_cnt;

    logic        mid_packet;
    logic        timed_out;
    logic        sync_byte;
    logic        accept_hdr;
    logic        latch_dx;
    logic        latch_dy;

    logic signed [13:0] dx_ext;
    logic signed [13:0] dy_ext;
    logic signed [13:0] nx;
    logic signed [13:0] ny;
    logic [11:0]        x_new;
    logic [11:0]        y_new;

    assign mid_packet = (state == WAIT_B1) || (state == WAIT_B2);
    assign timed_out  = mid_packet && (timeout_cnt == TIMEOUT_LIM);
    assign sync_byte  = rx_valid && rx_data[3];

    // -----------------------------------------------------------------------
    // Next-state logic. During APPLY, and in the cycle a partial packet
    // times out, the state machine already behaves like WAIT_B0. A header
    // that arrives in either of those cycles therefore starts a new packet
    // and is not lost.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept_hdr = 1'b0;
        latch_dx   = 1'b0;
        latch_dy   = 1'b0;
        case (state)
            WAIT_B0, APPLY: begin
                state_next = WAIT_B0;
                if (sync_byte) begin
                    accept_hdr = 1'b1;
                    state_next = WAIT_B1;
                end
            end
            WAIT_B1: begin
                if (timed_out) begin
                    state_next = WAIT_B0;
                    if (sync_byte) begin
                        accept_hdr = 1'b1;
                        state_next = WAIT_B1;
                    end
                end else if (rx_valid) begin
                    latch_dx   = 1'b1;
                    state_next = WAIT_B2;
                end
            end
            WAIT_B2: begin
                if (timed_out) begin
                    state_next = WAIT_B0;
                    if (sync_byte) begin
                        accept_hdr = 1'b1;
                        state_next = WAIT_B1;
                    end
                end else if (rx_valid) begin
                    latch_dy   = 1'b1;
                    state_next = APPLY;
                end
            end
            default: state_next = WAIT_B0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_B0;
        end else begin
            state <= state_next;
        end
    end

    // The inter-byte gap counter runs only while a packet is partially
    // assembled. It restarts on every byte and whenever the FSM goes back
    // to WAIT_B0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_cnt <= '0;
        end else if (rx_valid || !mid_packet || (state_next == WAIT_B0)) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= timeout_cnt + 21'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr     <= '0;
            dx_byte <= '0;
            dy_byte <= '0;
        end else begin
            if (accept_hdr) hdr     <= rx_data;
            if (latch_dx)   dx_byte <= rx_data;
            if (latch_dy)   dy_byte <= rx_data;
        end
    end

    // -----------------------------------------------------------------------
    // Delta arithmetic. The 9-bit deltas {sign, byte} are sign-extended to
    // 14 bits. An axis whose overflow bit is set contributes no movement.
    // The Y delta is subtracted because PS/2 +Y points up while screen Y
    // grows downward.
    // -----------------------------------------------------------------------
    always_comb begin
        dx_ext = hdr[6] ? 14'sd0 : {{6{hdr[4]}}, dx_byte};
        dy_ext = hdr[7] ? 14'sd0 : {{6{hdr[5]}}, dy_byte};
        nx     = $signed({2'b00, xpos}) + dx_ext;
        ny     = $signed({2'b00, ypos}) - dy_ext;

        x_new = nx[11:0];
        if (nx < 14'sd0) begin
            x_new = '0;
        end else if (nx > XMAX_S) begin
            x_new = 12'(XMAX);
        end

        y_new = ny[11:0];
        if (ny < 14'sd0) begin
            y_new = '0;
        end else if (ny > YMAX_S) begin
            y_new = 12'(YMAX);
        end
    end

`ifdef MOUSE_CLICK_PULSE_EN
    // Left level from the previously applied packet. A click is reported
    // only on a rising edge, so a held button cannot retrigger downstream
    // toggles.
    logic prev_left;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xpos        <= 12'(XINIT);
            ypos        <= 12'(YINIT);
            ButtonLeft  <= 1'b0;
            ButtonRight <= 1'b0;
            pkt_valid   <= 1'b0;
`ifdef MOUSE_CLICK_PULSE_EN
            prev_left   <= 1'b0;
`endif
        end else begin
            pkt_valid <= (state == APPLY);
`ifdef MOUSE_CLICK_PULSE_EN
            ButtonLeft <= (state == APPLY) && hdr[0] && !prev_left;
`endif
            if (state == APPLY) begin
                xpos        <= x_new;
                ypos        <= y_new;
                ButtonRight <= hdr[1];
`ifdef MOUSE_CLICK_PULSE_EN
                prev_left   <= hdr[0];
`else
                ButtonLeft  <= hdr[0];
`endif
            end
        end
    end

endmodule

// File: tb/tb_mouse_position_tracker.sv
// ---------------------------------------------------------------------------
// Testbench for mouse_position_tracker.
// It applies directed byte sequences. A packet-level model, kept in terms of
// bytes, cycle gaps and integer arithmetic, predicts the outputs, and a
// compare process checks every DUT output on every cycle. Hand-computed
// literal expectations pin the key results.
// The timeout is shortened so that the gap test stays brief.
// ---------------------------------------------------------------------------
module tb_mouse_position_tracker;

    localparam int TO    = 200;
    localparam int XMAXV = 1023;
    localparam int YMAXV = 767;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        ButtonLeft;
    logic        ButtonRight;
    logic        pkt_valid;

    always #5 clk = ~clk;

    mouse_position_tracker #(
        .XMAX(1023), .YMAX(767), .XINIT(512), .YINIT(384), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .xpos(xpos),
        .ypos(ypos),
        .ButtonLeft(ButtonLeft),
        .ButtonRight(ButtonRight),
        .pkt_valid(pkt_valid)
    );

    // ---------------- scoreboard counters ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_x = 512, m_y = 384;
    bit         m_l = 0, m_r = 0, m_pkt = 0, m_prev_l = 0;
    logic [7:0] pend [3];
    int         pend_n = 0;
    int         cyc = 0, last_cyc = 0;
    bit         pipe_v = 0;
    int         p_x, p_y;
    bit         p_l, p_r;
    bit         cmp_en = 0;

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // The packet is complete: work out the outputs that must appear two
    // cycles later.
    task automatic model_packet();
        int dx, dy;
        dx = pend[0][6] ? 0 : (pend[0][4] ? int'(pend[1]) - 256 : int'(pend[1]));
        dy = pend[0][7] ? 0 : (pend[0][5] ? int'(pend[2]) - 256 : int'(pend[2]));
        p_x = clampi(m_x + dx, XMAXV);
        p_y = clampi(m_y - dy, YMAXV);
        p_r = pend[0][1];
`ifdef MOUSE_CLICK_PULSE_EN
        p_l      = pend[0][0] && !m_prev_l;
        m_prev_l = pend[0][0];
`else
        p_l = pend[0][0];
`endif
        pipe_v = 1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_x = 512; m_y = 384; m_l = 0; m_r = 0; m_pkt = 0; m_prev_l = 0;
            pend_n = 0; pipe_v = 0;
        end else begin
            m_pkt = 0;
`ifdef MOUSE_CLICK_PULSE_EN
            m_l = 0;
`endif
            if (pipe_v) begin
                m_x = p_x; m_y = p_y; m_l = p_l; m_r = p_r; m_pkt = 1; pipe_v = 0;
            end
            if (rx_valid) begin
                if (pend_n > 0 && (cyc - last_cyc) > TO) pend_n = 0;
                last_cyc = cyc;
                if (pend_n == 0) begin
                    if (rx_data[3]) begin
                        pend[0] = rx_data;
                        pend_n  = 1;
                    end
                end else begin
                    pend[pend_n] = rx_data;
                    pend_n++;
                    if (pend_n == 3) begin
                        model_packet();
                        pend_n = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("xpos",        int'(xpos),        rst ? 512 : m_x);
            check("ypos",        int'(ypos),        rst ? 384 : m_y);
            check("ButtonLeft",  int'(ButtonLeft),  rst ? 0 : int'(m_l));
            check("ButtonRight", int'(ButtonRight), rst ? 0 : int'(m_r));
            check("pkt_valid",   int'(pkt_valid),   rst ? 0 : int'(m_pkt));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_data = 8'h00;
    endtask

    // Three bytes on consecutive cycles. Returns 1 time unit after the edge
    // that samples the third byte.
    task automatic send_pkt(input logic [7:0] h, input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = h;
        @(posedge clk); #1; rx_data = a;
        @(posedge clk); #1; rx_data = b;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_data = 8'h00;
    endtask

    // Two packets with no gap, so the second header lands in the APPLY cycle.
    task automatic burst6(input logic [7:0] h0, input logic [7:0] a0, input logic [7:0] b0,
                          input logic [7:0] h1, input logic [7:0] a1, input logic [7:0] b1);
        logic [7:0] bs [6];
        bs[0] = h0; bs[1] = a0; bs[2] = b0; bs[3] = h1; bs[4] = a1; bs[5] = b1;
        @(posedge clk); #1;
        rx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rx_data = bs[i];
            @(posedge clk); #1;
        end
        rx_valid = 1'b0; rx_data = 8'h00;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int bl_high = 0;
    bit bl_count_en = 0;
    initial forever begin
        @(negedge clk);
        if (bl_count_en && ButtonLeft) bl_high++;
    end

    initial begin
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #2 rst = 1'b1;
        #1 cmp_en = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        idle(10);
        check("idle_x", int'(xpos), 512);
        check("idle_y", int'(ypos), 384);
        check("idle_bl", int'(ButtonLeft), 0);
        check("idle_pv", int'(pkt_valid), 0);

        // Basic packet and its latency: dx=+10, dy=+5
        send_pkt(8'h08, 8'h0A, 8'h05);
        check("lat_pv_n1", int'(pkt_valid), 0);
        idle(1);
        check("lat_pv_n2", int'(pkt_valid), 1);
        check("basic_x", int'(xpos), 522);
        check("basic_y", int'(ypos), 379);
        idle(1);
        check("lat_pv_n3", int'(pkt_valid), 0);

        // Negative deltas on both axes: dx=-10, dy=-5
        do_reset();
        send_pkt(8'h38, 8'hF6, 8'hFB);
        idle(3);
        check("neg_x", int'(xpos), 502);
        check("neg_y", int'(ypos), 389);

        // Clamp at the left edge
        do_reset();
        repeat (3) send_pkt(8'h18, 8'h00, 8'h00);
        idle(3);
        check("clamp_x0", int'(xpos), 0);
        check("clamp_x0_y", int'(ypos), 384);

        // Clamp at the right edge
        do_reset();
        repeat (3) send_pkt(8'h08, 8'hFF, 8'h00);
        idle(3);
        check("clamp_xmax", int'(xpos), 1023);

        // Clamp at the bottom edge
        do_reset();
        repeat (2) send_pkt(8'h28, 8'h00, 8'h00);
        idle(3);
        check("clamp_ymax", int'(ypos), 767);

        // Overflow bit on X: X is frozen, Y moves
        do_reset();
        send_pkt(8'h4A, 8'hFF, 8'h05);
        idle(3);
        check("ovf_x", int'(xpos), 512);
        check("ovf_y", int'(ypos), 379);
        check("ovf_br", int'(ButtonRight), 1);

        // Resync: bytes without the sync bit are dropped
        do_reset();
        send(8'h00);
        send(8'h02);
        send_pkt(8'h09, 8'h00, 8'h00);
        idle(1);
        check("resync_pv", int'(pkt_valid), 1);
        check("resync_bl", int'(ButtonLeft), 1);
        check("resync_x", int'(xpos), 512);
        check("resync_y", int'(ypos), 384);

        // Timeout drops a partial packet
        do_reset();
        send(8'h08);
        send(8'h10);
        idle(TO + 5);
        send_pkt(8'h08, 8'h01, 8'h01);
        idle(3);
        check("timeout_x", int'(xpos), 513);
        check("timeout_y", int'(ypos), 383);

        // Back-to-back: the second header arrives during APPLY
        do_reset();
        burst6(8'h08, 8'h05, 8'h00, 8'h0A, 8'h03, 8'h00);
        idle(4);
        check("b2b_x", int'(xpos), 520);
        check("b2b_br", int'(ButtonRight), 1);

        // Reset in the middle of a packet
        do_reset();
        send_pkt(8'h08, 8'h10, 8'h10);
        send(8'h08);
        send(8'h01);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_x", int'(xpos), 512);
        check("midrst_y", int'(ypos), 384);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(8'h05);
        send(8'h05);
        send_pkt(8'h08, 8'h01, 8'h01);
        idle(3);
        check("midrst_after_x", int'(xpos), 513);
        check("midrst_after_y", int'(ypos), 383);

        // Left-button sequence: held, released, pressed again
        do_reset();
        bl_count_en = 1;
        repeat (3) send_pkt(8'h09, 8'h00, 8'h00);
        send_pkt(8'h08, 8'h00, 8'h00);
        idle(3);
        check("btn_release", int'(ButtonLeft), 0);
        send_pkt(8'h09, 8'h00, 8'h00);
        idle(3);
        bl_count_en = 0;
`ifdef MOUSE_CLICK_PULSE_EN
        check("btn_pulse_count", bl_high, 2);
        check("btn_pulse_idle", int'(ButtonLeft), 0);
`else
        check("btn_level", int'(ButtonLeft), 1);
`endif

        idle(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the sequence above needs only about a thousand cycles.
    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mouse_position_tracker.md
Name: mouse_position_tracker

Overview:
- Feeds the menu/map controller with cursor position and button state.
- Takes decoded PS/2 mouse bytes from the serial receiver, reassembles standard 3-byte movement packets, and integrates the signed X/Y deltas into an absolute screen position.
- The position is clamped to the 1024x768 display.
- Outputs xpos, ypos and ButtonLeft, registered, and connect directly to the controller inputs of the same names.

Parameters:
- XMAX, 1023, largest legal xpos.
- YMAX, 767, largest legal ypos.
- XINIT, 512, xpos after reset.
- YINIT, 384, ypos after reset.
- TIMEOUT_CYCLES, 1300000, maximum clk cycles allowed between bytes of one packet (about 20 ms at 65 MHz). Must be below 2^21.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous and active-high.
- rx_data  in  8  byte from the PS/2 receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- xpos  out  12  cursor X, 0..XMAX.
- ypos  out  12  cursor Y, 0..YMAX; 0 is the top of the screen.
- ButtonLeft  out  1  left button state.
- ButtonRight  out  1  right button state.
- pkt_valid  out  1  one-cycle pulse when a packet has been applied.

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - state = WAIT_B0, timeout counter = 0.
  - xpos = XINIT, ypos = YINIT.
  - ButtonLeft = 0, ButtonRight = 0, pkt_valid = 0.
  - Any partially assembled packet is discarded.
- State machine:
  - WAIT_B0:
    - On rx_valid with rx_data[3] = 1 (sync bit): latch the byte as the header, go to WAIT_B1.
    - On rx_valid with rx_data[3] = 0: drop the byte, stay in WAIT_B0.
  - WAIT_B1: on rx_valid, latch the byte as dx, go to WAIT_B2.
  - WAIT_B2: on rx_valid, latch the byte as dy, go to APPLY.
  - APPLY (one cycle): update the outputs, pulse pkt_valid, return to WAIT_B0.
  - A byte arriving while in APPLY is handled as a WAIT_B0 byte in the same cycle; no byte is lost.
- Timeout:
  - A 21-bit counter clears on every rx_valid and on entry to WAIT_B0.
  - It increments in WAIT_B1 and WAIT_B2.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to WAIT_B0 and the partial packet is dropped.
- Header bits:
  - [0] left button, [1] right button.
  - [4] X sign, [5] Y sign.
  - [6] X overflow, [7] Y overflow.
- Arithmetic:
  - Deltas are 9-bit two's complement: {sign, byte}.
  - Sign-extend to 14 bits signed.
  - X: nx = xpos + dx. Y: ny = ypos - dy (PS/2 +Y is up).
  - If the result is < 0 it clamps to 0. If it is > XMAX or YMAX it clamps to that maximum.
  - If an axis overflow bit is set, that axis delta is forced to 0; the buttons still update.
- Latency: the third byte's rx_valid is in cycle N. In cycle N+1 the FSM is in APPLY. In cycle N+2 the new xpos, ypos and buttons are visible and pkt_valid is 1 for exactly that cycle.
- Between packets all outputs hold their values; pkt_valid = 0.
- Reset mid-packet: immediate return to the reset values. The next packet must start with a valid header.

Optional Feature:
- Macro: MOUSE_CLICK_PULSE_EN.
- When defined: ButtonLeft is a one-cycle pulse, asserted together with pkt_valid only when the packet's left bit is 1 and the previous packet's left bit was 0. An internal register tracks the previous left level and resets to 0. This prevents a held button from toggling the controller's menu/map state every cycle.
- When undefined: ButtonLeft is the level from the most recent packet.
- ButtonRight is always a level.

Test Plan:
- Reset release, no input -> xpos=512, ypos=384, ButtonLeft=0, pkt_valid=0 indefinitely.
- Bytes 0x08, 0x0A, 0x05 -> two cycles after the third strobe: xpos=522, ypos=379, pkt_valid pulses once.
- Clamping:
  - Bytes 0x18, 0x00 (dx=-256), repeated 3 times -> xpos=0, not wrapped.
  - Bytes 0x08, 0xFF, 0x00, repeated 3 times from xpos=512 -> xpos=1023.
  - Bytes 0x28, 0x00, 0x00 (dy=-256), twice from ypos=384 -> ypos=767.
- Resync: bytes 0x00, 0x02 (sync=0, both dropped), then 0x09, 0x00, 0x00 -> one packet applied, ButtonLeft=1, position unchanged.
- Timeout: 0x08, 0x10, then a gap of TIMEOUT_CYCLES+5, then 0x08, 0x01, 0x01 -> only the second packet applies; xpos=513, ypos=383.
- MOUSE_CLICK_PULSE_EN defined: three packets with header 0x09 -> ButtonLeft high only in the first packet's pulse cycle. Then 0x08, then 0x09 -> pulses again. Reset asserted between bytes 1 and 2 -> outputs return to the reset values immediately.
